// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scanout path.
//   - 640x480@60 raster timing constants
//   - source framebuffer geometry (320x240, 4 bpp, two pixels per byte)
//   - colour and palette-index types
package vga_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_TOTAL   = 800;
    localparam int V_DISPLAY = 480;
    localparam int V_TOTAL   = 525;

    localparam int FB_STRIDE = 160;   // bytes per source line
    localparam int SRC_W     = 320;
    localparam int SRC_H     = 240;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef logic [3:0] pal_idx_t;

endpackage

// File: rtl/vga_palette.sv
// 16-entry colour look-up table.
//   clk, rst_n  : clock, asynchronous active-low clear of every entry
//   we/waddr/wdata : write port, entry updates on the clock edge
//   raddr/rdata : combinational read port; a read in the same cycle as a
//                 write to the same entry returns the old contents
module vga_palette
    import vga_pkg::*;
#(
    parameter int RGB_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  pal_idx_t         waddr,
    input  logic [RGB_W-1:0] wdata,
    input  pal_idx_t         raddr,
    output logic [RGB_W-1:0] rdata
);

    logic [RGB_W-1:0] entries [16];

    // NOTE: the table is small enough to live in flops, so it can be cleared
    // on reset; a true RAM macro could not be reset this way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                entries[i] <= '0;
            end
        end else if (we) begin
            entries[waddr] <= wdata;
        end
    end

    assign rdata = entries[raddr];

endmodule

// File: rtl/vga_scanout.sv
// Pixel stage behind the 640x480@60 timing generator.
// Reads a 320x240 4bpp framebuffer (1-cycle synchronous read), doubles each
// source pixel 2x2, maps it through a writable palette and drives 12-bit RGB.
//   clk_25mhz, reset         : pixel clock, asynchronous active-low reset
//   hsync_in/vsync_in/h_count/v_count/display_enable : raster timing in
//   test_mode                : colour bars instead of framebuffer data
//   fb_rd_en/fb_addr/fb_data : framebuffer read port
//   pal_we/pal_addr/pal_data : palette write port
//   hsync/vsync/de/rgb/frame_start : outputs, all PIPE_LAT cycles behind input
module vga_scanout
    import vga_pkg::pal_idx_t;
#(
    parameter int FB_ADDR_W = 16,
    parameter int FB_STRIDE = vga_pkg::FB_STRIDE,
    parameter int PIPE_LAT  = 3,
    parameter int RGB_W     = 12
) (
    input  logic                 clk_25mhz,
    input  logic                 reset,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic [9:0]           h_count,
    input  logic [9:0]           v_count,
    input  logic                 display_enable,
    input  logic                 test_mode,
    output logic                 fb_rd_en,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [7:0]           fb_data,
    input  logic                 pal_we,
    input  logic [3:0]           pal_addr,
    input  logic [RGB_W-1:0]     pal_data,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [RGB_W-1:0]     rgb,
    output logic                 frame_start
);

    // Source coordinates: every source pixel covers 2x2 output pixels.
    logic [8:0] sx;
    logic [8:0] sy;
    assign sx = h_count[9:1];
    assign sy = v_count[9:1];

    logic unused_lsbs;
    assign unused_lsbs = ^{h_count[0], v_count[0]};

    logic [FB_ADDR_W-1:0] line_base;
    generate
        if (FB_STRIDE == 160) begin : g_stride_shift
            // 160 = 128 + 32, so the multiply collapses to two shifts and an add.
            assign line_base = (FB_ADDR_W'(sy) << 7) + (FB_ADDR_W'(sy) << 5);
        end else begin : g_stride_mul
            assign line_base = FB_ADDR_W'(sy * FB_STRIDE);
        end
    endgenerate

    // Timing side-band delay lines; bit 0 is the newest sample.
    logic [PIPE_LAT-1:0] hs_q;
    logic [PIPE_LAT-1:0] vs_q;
    logic [PIPE_LAT-1:0] de_q;
    logic [PIPE_LAT-1:0] fs_q;

    logic frame_origin;
    assign frame_origin = (h_count == 10'd0) && (v_count == 10'd0);

    // Pixel-select side-band: stage 0 travels with fb_addr, stage 1 lines up
    // with fb_data coming back from the memory.
    logic     nib_s0, nib_s1;
    logic     tm_s0,  tm_s1;
    pal_idx_t bar_s0, bar_s1;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the values from before the edge, regardless of statement order.
    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            hs_q     <= '0;
            vs_q     <= '0;
            de_q     <= '0;
            fs_q     <= '0;
            fb_addr  <= '0;
            fb_rd_en <= 1'b0;
            nib_s0   <= 1'b0;
            tm_s0    <= 1'b0;
            bar_s0   <= '0;
            nib_s1   <= 1'b0;
            tm_s1    <= 1'b0;
            bar_s1   <= '0;
        end else begin
            hs_q     <= {hs_q[PIPE_LAT-2:0], hsync_in};
            vs_q     <= {vs_q[PIPE_LAT-2:0], vsync_in};
            de_q     <= {de_q[PIPE_LAT-2:0], display_enable};
            fs_q     <= {fs_q[PIPE_LAT-2:0], frame_origin};
            // Address keeps tracking in blanking; only the strobe is gated.
            fb_addr  <= line_base + FB_ADDR_W'(sx[8:1]);
            fb_rd_en <= display_enable & ~test_mode;
            nib_s0   <= sx[0];
            tm_s0    <= test_mode;
            bar_s0   <= h_count[9:6];
            nib_s1   <= nib_s0;
            tm_s1    <= tm_s0;
            bar_s1   <= bar_s0;
        end
    end

    pal_idx_t pix_idx;

    // NOTE: give every always_comb output a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        pix_idx = bar_s1;
        if (!tm_s1) begin
            pix_idx = nib_s1 ? fb_data[7:4] : fb_data[3:0];
        end
    end

    logic [RGB_W-1:0] pal_colour;

    vga_palette #(
        .RGB_W (RGB_W)
    ) u_palette (
        .clk   (clk_25mhz),
        .rst_n (reset),
        .we    (pal_we),
        .waddr (pal_addr),
        .wdata (pal_data),
        .raddr (pix_idx),
        .rdata (pal_colour)
    );

    // de_q[PIPE_LAT-2] is the enable belonging to the pixel now in pix_idx.
    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            rgb <= '0;
        end else begin
            rgb <= de_q[PIPE_LAT-2] ? pal_colour : '0;
        end
    end

    assign hsync       = hs_q[PIPE_LAT-1];
    assign vsync       = vs_q[PIPE_LAT-1];
    assign de          = de_q[PIPE_LAT-1];
    assign frame_start = fs_q[PIPE_LAT-1];

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: reset, framebuffer path across a frame
// wrap, bottom-right corner address, blanking, colour bars and palette
// write/read collision.
module tb_vga_scanout;

    logic        clk_25mhz = 1'b0;
    logic        reset;
    logic        hsync_in, vsync_in;
    logic [9:0]  h_count, v_count;
    logic        display_enable, test_mode;
    logic        fb_rd_en;
    logic [15:0] fb_addr;
    logic [7:0]  fb_data = 8'h00;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [11:0] pal_data;
    logic        hsync, vsync, de, frame_start;
    logic [11:0] rgb;

    always #20 clk_25mhz = ~clk_25mhz;

    vga_scanout #(
        .FB_ADDR_W (16),
        .FB_STRIDE (160),
        .PIPE_LAT  (3),
        .RGB_W     (12)
    ) dut (
        .clk_25mhz      (clk_25mhz),
        .reset          (reset),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .h_count        (h_count),
        .v_count        (v_count),
        .display_enable (display_enable),
        .test_mode      (test_mode),
        .fb_rd_en       (fb_rd_en),
        .fb_addr        (fb_addr),
        .fb_data        (fb_data),
        .pal_we         (pal_we),
        .pal_addr       (pal_addr),
        .pal_data       (pal_data),
        .hsync          (hsync),
        .vsync          (vsync),
        .de             (de),
        .rgb            (rgb),
        .frame_start    (frame_start)
    );

    // Framebuffer model with one-cycle read latency.
    logic [7:0] fb_mem [0:65535];
    always @(posedge clk_25mhz) begin
        if (fb_rd_en) fb_data <= fb_mem[fb_addr];
    end

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs, vs, de, fs, rd;
        logic [11:0] rgb;
        logic [15:0] addr;
    } exp_t;

    logic [11:0] pal_m [16];
    exp_t        hist [3];   // [0] newest sample, [2] due on the outputs now
    int          checks = 0;
    int          passes = 0;

    function automatic exp_t model(input logic [9:0] h, input logic [9:0] v,
                                   input logic en, input logic hs,
                                   input logic vs, input logic tm);
        exp_t        e;
        int          a;
        logic [7:0]  b;
        logic [3:0]  idx;
        a      = int'(v[9:1]) * 160 + int'(h[9:2]);
        e.h    = h;
        e.v    = v;
        e.hs   = hs;
        e.vs   = vs;
        e.de   = en;
        e.fs   = (h == 10'd0) && (v == 10'd0);
        e.rd   = en & ~tm;
        e.addr = 16'(a);
        b      = fb_mem[e.addr];
        idx    = tm ? h[9:6] : (h[1] ? b[7:4] : b[3:0]);
        e.rgb  = en ? pal_m[idx] : 12'h000;
        return e;
    endfunction

    task automatic clear_hist();
        for (int i = 0; i < 3; i++) begin
            hist[i] = '{h: 10'd0, v: 10'd0, hs: 1'b0, vs: 1'b0, de: 1'b0,
                        fs: 1'b0, rd: 1'b0, rgb: 12'h000, addr: 16'h0000};
        end
    endtask

    task automatic set_pos(input int h, input int v);
        h_count        = 10'(h);
        v_count        = 10'(v);
        display_enable = (h < 640) && (v < 480);
        hsync_in       = !((h >= 656) && (h < 752));
        vsync_in       = !((v >= 490) && (v < 492));
    endtask

    // One clock: expectation captured from the inputs the edge samples,
    // outputs then settle 1 time unit after the edge.
    task automatic step();
        exp_t e;
        e = model(h_count, v_count, display_enable, hsync_in, vsync_in, test_mode);
        @(posedge clk_25mhz);
        #1;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = e;
    endtask

    task automatic pal_write(input int a, input logic [11:0] d);
        pal_we   = 1'b1;
        pal_addr = 4'(a);
        pal_data = d;
        step();
        pal_we      = 1'b0;
        pal_m[4'(a)] = d;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_25mhz);
        #1;
        checks++;
        if ({hsync, vsync, de, frame_start, fb_rd_en, rgb, fb_addr} !== 33'd0)
            $display("FAIL power_on_reset got hs=%b vs=%b de=%b fs=%b rd=%b rgb=%h addr=%0d want all zero",
                     hsync, vsync, de, frame_start, fb_rd_en, rgb, fb_addr);
        else passes++;
        reset = 1'b1;
        clear_hist();
        pal_write(0, 12'hFFF);
        test_mode = 1'b1;
        for (int h = 0; h < 8; h++) begin
            set_pos(h, 10);
            step();
        end
        checks++;
        if (rgb !== 12'hFFF || de !== 1'b1 || hsync !== 1'b1)
            $display("FAIL pre_reset_active got rgb=%h de=%b hs=%b want rgb=fff de=1 hs=1", rgb, de, hsync);
        else passes++;
        #5 reset = 1'b0;
        #1;
        checks++;
        if ({hsync, vsync, de, frame_start, fb_rd_en, rgb, fb_addr} !== 33'd0)
            $display("FAIL mid_line_reset got hs=%b vs=%b de=%b fs=%b rd=%b rgb=%h addr=%0d want all zero",
                     hsync, vsync, de, frame_start, fb_rd_en, rgb, fb_addr);
        else passes++;
        for (int i = 0; i < 16; i++) pal_m[i] = 12'h000;
        clear_hist();
        repeat (2) @(posedge clk_25mhz);
        #1 reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_pos(8 + k, 10);
            step();
            checks++;
            if (de !== (k >= 2) || rgb !== 12'h000)
                $display("FAIL refill k=%0d got de=%b rgb=%h want de=%b rgb=000", k, de, rgb, (k >= 2));
            else passes++;
        end
    endtask

    task automatic test_frame();
        int h, v, fs_cnt;
        test_mode = 1'b0;
        set_pos(700, 300);
        fb_mem[0] = 8'h55;
        for (int i = 1; i < 320; i++) fb_mem[i] = 8'((i * 37) & 255);
        for (int i = 0; i < 16; i++) pal_write(i, 12'((i * 12'h123) & 12'hFFF));
        pal_write(5, 12'hF0A);
        h = 790;
        v = 524;
        fs_cnt = 0;
        for (int n = 0; n < 1630; n++) begin
            set_pos(h, v);
            step();
            checks++;
            if ({hsync, vsync, de, frame_start, rgb} !==
                {hist[2].hs, hist[2].vs, hist[2].de, hist[2].fs, hist[2].rgb})
                $display("FAIL frame_stream h=%0d v=%0d got hs/vs/de/fs=%b%b%b%b rgb=%h want %b%b%b%b rgb=%h",
                         hist[2].h, hist[2].v, hsync, vsync, de, frame_start, rgb,
                         hist[2].hs, hist[2].vs, hist[2].de, hist[2].fs, hist[2].rgb);
            else passes++;
            checks++;
            if ({fb_rd_en, fb_addr} !== {hist[0].rd, hist[0].addr})
                $display("FAIL frame_fb_port h=%0d v=%0d got rd=%b addr=%0d want rd=%b addr=%0d",
                         hist[0].h, hist[0].v, fb_rd_en, fb_addr, hist[0].rd, hist[0].addr);
            else passes++;
            if (hist[2].de && hist[2].v < 2 && hist[2].h < 4) begin
                checks++;
                if (rgb !== 12'hF0A)
                    $display("FAIL origin_pixel x=%0d y=%0d got rgb=%h want f0a", hist[2].h, hist[2].v, rgb);
                else passes++;
            end
            if (frame_start) begin
                fs_cnt++;
                checks++;
                if (rgb !== 12'hF0A || de !== 1'b1)
                    $display("FAIL frame_start_align got rgb=%h de=%b want rgb=f0a de=1", rgb, de);
                else passes++;
            end
            h++;
            if (h == 800) begin
                h = 0;
                v++;
                if (v == 525) v = 0;
            end
        end
        checks++;
        if (fs_cnt !== 1)
            $display("FAIL frame_start_count got %0d want 1", fs_cnt);
        else passes++;
    endtask

    task automatic test_corner();
        test_mode = 1'b0;
        set_pos(700, 300);
        fb_mem[38399] = 8'hA3;
        pal_write(10, 12'hABC);
        set_pos(638, 479);
        step();
        checks++;
        if (fb_addr !== 16'd38399 || fb_rd_en !== 1'b1)
            $display("FAIL corner_addr got addr=%0d rd=%b want addr=38399 rd=1", fb_addr, fb_rd_en);
        else passes++;
        set_pos(639, 479);
        step();
        set_pos(640, 479);
        step();
        checks++;
        if (rgb !== 12'hABC || de !== 1'b1)
            $display("FAIL corner_x638 got rgb=%h de=%b want rgb=abc de=1", rgb, de);
        else passes++;
        set_pos(641, 479);
        step();
        checks++;
        if (rgb !== 12'hABC || de !== 1'b1)
            $display("FAIL corner_x639 got rgb=%h de=%b want rgb=abc de=1", rgb, de);
        else passes++;
        set_pos(642, 479);
        step();
        checks++;
        if (rgb !== 12'h000 || de !== 1'b0)
            $display("FAIL corner_x640 got rgb=%h de=%b want rgb=000 de=0", rgb, de);
        else passes++;
    endtask

    task automatic test_blanking();
        test_mode = 1'b0;
        set_pos(700, 300);
        pal_write(0, 12'h0F0);
        for (int n = 0; n < 803; n++) begin
            set_pos(n % 800, 200 + n / 800);
            step();
            checks++;
            if ({hsync, vsync, de, rgb} !== {hist[2].hs, hist[2].vs, hist[2].de, hist[2].rgb})
                $display("FAIL line_stream h=%0d got hs/vs/de=%b%b%b rgb=%h want %b%b%b rgb=%h",
                         hist[2].h, hsync, vsync, de, rgb, hist[2].hs, hist[2].vs, hist[2].de, hist[2].rgb);
            else passes++;
            if (n >= 3 && hist[2].h >= 640) begin
                checks++;
                if (rgb !== 12'h000 || de !== 1'b0)
                    $display("FAIL blanking h=%0d got rgb=%h de=%b want rgb=000 de=0", hist[2].h, rgb, de);
                else passes++;
            end
        end
    endtask

    task automatic test_colour_bars();
        int rd_seen;
        test_mode = 1'b0;
        set_pos(700, 300);
        for (int i = 0; i < 10; i++) pal_write(i, 12'(i * 12'h111));
        test_mode = 1'b1;
        rd_seen = 0;
        for (int n = 0; n < 803; n++) begin
            set_pos(n % 800, 100 + n / 800);
            step();
            if (fb_rd_en !== 1'b0) rd_seen++;
            if (n >= 3 && hist[2].de) begin
                checks++;
                if (rgb !== 12'((hist[2].h / 64) * 12'h111))
                    $display("FAIL colour_bar h=%0d got rgb=%h want %h",
                             hist[2].h, rgb, 12'((hist[2].h / 64) * 12'h111));
                else passes++;
            end
        end
        checks++;
        if (rd_seen !== 0)
            $display("FAIL bars_no_read got %0d strobes want 0", rd_seen);
        else passes++;
    endtask

    task automatic test_palette_collision();
        test_mode = 1'b0;
        set_pos(700, 300);
        pal_write(3, 12'h777);
        test_mode = 1'b1;
        set_pos(192, 100);
        step();
        set_pos(193, 100);
        step();
        // This edge both writes entry 3 and registers pixel 192's lookup.
        pal_we   = 1'b1;
        pal_addr = 4'd3;
        pal_data = 12'h123;
        set_pos(194, 100);
        step();
        pal_we   = 1'b0;
        pal_m[3] = 12'h123;
        checks++;
        if (rgb !== 12'h777)
            $display("FAIL collision_old got rgb=%h want 777", rgb);
        else passes++;
        set_pos(195, 100);
        step();
        checks++;
        if (rgb !== 12'h123)
            $display("FAIL collision_new got rgb=%h want 123", rgb);
        else passes++;
    endtask

    initial begin
        reset          = 1'b0;
        hsync_in       = 1'b1;
        vsync_in       = 1'b1;
        h_count        = 10'd700;
        v_count        = 10'd300;
        display_enable = 1'b0;
        test_mode      = 1'b0;
        pal_we         = 1'b0;
        pal_addr       = 4'd0;
        pal_data       = 12'h000;
        for (int i = 0; i < 65536; i++) fb_mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) pal_m[i] = 12'h000;
        clear_hist();

        test_reset();
        test_frame();
        test_corner();
        test_blanking();
        test_colour_bars();
        test_palette_collision();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
